// File: rtl/rr_arbiter16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// No logic of its own; the grant decode helper is purely combinational.
// No flow control lives here.
package rr_arbiter16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot decode of a requester index onto the request/grant vector
    function automatic logic [N_REQ-1:0] idx_decode(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin winner search: first set request at or after ptr, wrapping mod 16.
// Purely combinational, zero cycles.
// No backpressure; any=0 when nothing is requesting and idx is then don't-care (0).
module rr_pick16
    import rr_arbiter16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   offset;

    // Rotate right by ptr so that bit 0 of req_rot is requester ptr
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    // Priority-encode the lowest set bit; scanning downwards lets the lowest win
    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    // Undo the rotation; the 4-bit add wraps naturally mod 16
    assign idx = ptr + offset;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for one resource shared by 16 requesters, grant held until release.
// Latency: request sampled at edge N is granted at edge N+1; one dead IDLE cycle after every release.
// Backpressure: none; a grant is released by done, by the owner dropping req, or by the hold timeout.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_params
        $error("rr_arbiter16: MAX_HOLD must be 1..255 and fit in CNT_W bits");
    end

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic             at_max;
    logic             release_grant;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req     = req[gnt_idx];
    assign at_max        = (hold_cnt == CNT_W'(MAX_HOLD));
    assign release_grant = done | ~owner_req | at_max;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant whenever anyone asks, return to IDLE on any release
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)      state_nxt = GRANT;
            GRANT:   if (release_grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the grant, pointer and hold counter for the current state
    always_comb begin
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = CNT_W'(1);
                end else begin
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    hold_nxt    = '0;
                    ptr_nxt     = gnt_idx + IDX_W'(1);
                    // Flag only a release caused purely by the hold limit
                    timeout_nxt = at_max & ~done & owner_req;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Registered outputs and datapath state; gnt is the decode of the next index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            gnt       <= valid_nxt ? idx_decode(idx_nxt) : '0;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: vector table plus hand-written sequences.
// Expected outputs are queued when inputs are driven and compared after the edge.
// Runs with the default MAX_HOLD=8.
module tb_rr_arbiter16;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        vld;
        logic [3:0]  idx;
        logic        tmo;
    } vec_t;

    typedef struct {
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        vld;
        logic        tmo;
        int          tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rr_arbiter16 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic r, input logic [15:0] q, input logic d,
                                input logic v, input logic [3:0] i, input logic t);
        vec_t x;
        x.rst = r; x.req = q; x.done = d; x.vld = v; x.idx = i; x.tmo = t;
        tbl.push_back(x);
    endfunction

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: got empty queue, want one entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.vld || timeout !== e.tmo) begin
            failures++;
            $display("FAIL step tag=%0d: got gnt=%h idx=%0d vld=%b tmo=%b, want gnt=%h idx=%0d vld=%b tmo=%b",
                     e.tag, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.vld, e.tmo);
        end
    endtask

    // Drive inputs just after an edge, queue the outputs expected after the next edge
    task automatic step(input logic [15:0] r, input logic d, input logic v,
                        input logic [3:0] i, input logic t, input int tag);
        exp_t e;
        req    = r;
        done   = d;
        e.vld  = v;
        e.idx  = v ? i : 4'd0;
        e.gnt  = v ? (16'h0001 << i) : 16'h0000;
        e.tmo  = t;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic do_reset();
        req     = '0;
        done    = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        req     = '0;
        done    = 1'b0;
        reset_n = 1'b0;

        // Reset state
        #3;
        checks++;
        if (gnt !== 16'h0 || gnt_idx !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got gnt=%h idx=%0d vld=%b tmo=%b, want all zero",
                     gnt, gnt_idx, gnt_valid, timeout);
        end

        // Asynchronous reset while a grant is held
        do_reset();
        step(16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, 1000);
        step(16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, 1001);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 16'h0 || gnt_idx !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got gnt=%h idx=%0d vld=%b tmo=%b, want all zero before edge",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
        req = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) step(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1010 + k);

        // Single requester: grant, done on 3rd grant cycle, idle, re-grant, pointer moved
        add(1, 16'h0008, 0, 1, 3, 0);
        add(0, 16'h0008, 0, 1, 3, 0);
        add(0, 16'h0008, 0, 1, 3, 0);
        add(0, 16'h0008, 1, 0, 0, 0);
        add(0, 16'h0008, 0, 1, 3, 0);
        add(0, 16'h0008, 1, 0, 0, 0);
        add(0, 16'h0009, 0, 1, 0, 0);
        add(0, 16'h0009, 1, 0, 0, 0);
        add(0, 16'h0009, 0, 1, 3, 0);
        add(0, 16'h0000, 0, 0, 0, 0);
        // Pointer skip from ptr=5 with 8011: 15, 0, 4
        add(1, 16'h0010, 0, 1, 4, 0);
        add(0, 16'h0010, 1, 0, 0, 0);
        add(0, 16'h8011, 0, 1, 15, 0);
        add(0, 16'h8011, 1, 0, 0, 0);
        add(0, 16'h8011, 0, 1, 0, 0);
        add(0, 16'h8011, 1, 0, 0, 0);
        add(0, 16'h8011, 0, 1, 4, 0);
        add(0, 16'h8011, 1, 0, 0, 0);
        // Hold timeout: 8 grant cycles, single timeout pulse, re-grant
        add(1, 16'h0004, 0, 1, 2, 0);
        for (int k = 0; k < 7; k++) add(0, 16'h0004, 0, 1, 2, 0);
        add(0, 16'h0004, 0, 0, 0, 1);
        add(0, 16'h0004, 0, 1, 2, 0);
        // No preemption by requester 1, then done coinciding with the hold limit
        for (int k = 0; k < 7; k++) add(0, 16'h0006, 0, 1, 2, 0);
        add(0, 16'h0006, 1, 0, 0, 0);
        add(0, 16'h0006, 0, 1, 1, 0);
        add(0, 16'h0000, 0, 0, 0, 0);
        // Owner drops its request while 9 waits; done in IDLE is ignored
        add(1, 16'h0040, 0, 1, 6, 0);
        add(0, 16'h0040, 0, 1, 6, 0);
        add(0, 16'h0200, 0, 0, 0, 0);
        add(0, 16'h0200, 1, 1, 9, 0);
        add(0, 16'h0200, 1, 0, 0, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst) do_reset();
            step(tbl[n].req, tbl[n].done, tbl[n].vld, tbl[n].idx, tbl[n].tmo, n);
        end

        // Rotation with all requesters active: 0..15 then wrap to 0
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(16'hFFFF, 1'b0, 1'b1, 4'(k % 16), 1'b0, 2000 + 2 * k);
            step(16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, 2001 + 2 * k);
        end

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter sharing one resource among 16 requesters. The resource is addressed by a 4-bit select that feeds the 4-to-16 decode path.
- Registers a winner index and its one-hot grant, then holds the grant until the owner signals done, drops its request, or hits a hold timeout.
- Sits between requesting clients and the decoded shared resource; it is the only driver of the resource select.

Parameters:
- MAX_HOLD, 8: maximum cycles a grant is held before forced release; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  16  request vector; bit i belongs to requester i.
- done  in  1  owner releases the resource; sampled only in GRANT.
- gnt  out  16  registered one-hot grant; all zeros when no owner.
- gnt_idx  out  4  registered index of the current owner; 0 when none.
- gnt_valid  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, gnt=16'h0000, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
  - Next edge: gnt_idx=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency: req seen at edge N gives gnt at edge N+1.
- State GRANT, evaluated each cycle with o=gnt_idx. Release conditions, in priority order:
  1. done=1.
  2. req[o]=0.
  3. hold_cnt==MAX_HOLD, which also sets timeout=1 for exactly one cycle.
- On release at edge N:
  - gnt=0, gnt_valid=0, ptr=o+1 (4-bit wrap, 15 to 0), hold_cnt=0, state=IDLE.
- Otherwise in GRANT: hold_cnt increments and the grant is unchanged.
- Requests from other bits during GRANT have no effect. No preemption.
- After any release there is always exactly one IDLE cycle before the next grant. This gives the decoded resource a dead cycle.
- Simultaneous done and timeout condition: treat as a normal release, timeout=0.
- gnt is always one-hot or zero, and always equals the decode of gnt_idx while gnt_valid=1.
- Fairness: a continuously requesting client waits at most 15 grants.
- All outputs are registered; there is no combinational path from req or done to the outputs.

Decomposition:
- Shared package/header: state encodings IDLE=1'b0, GRANT=1'b1; constant N_REQ=16; IDX_W=4.
- Sub-module rr_pick16 (combinational):
  - Inputs: req[15:0], ptr[3:0]. Outputs: any, idx[3:0].
  - Implementation: rotate right by ptr, priority-encode the lowest set bit, add ptr mod 16.
- The top level holds the FSM, ptr, hold counter and grant registers; gnt is the decode of the next gnt_idx.

Test Plan:
- Reset and idle: reset_n=0 mid-grant with req=16'h0010. Outputs go to 0 asynchronously. Release reset with req=0: gnt stays 0000 for 5 cycles.
- Single requester: req=16'h0008, done pulsed on the 3rd grant cycle. gnt=0008 and gnt_idx=3 one edge after req. gnt drops the edge after done. One idle cycle, then re-grant to 3 with ptr having moved to 4.
- Rotation and wrap: req=16'hFFFF held, done pulsed every grant cycle. Grant order is 0,1,...,15,0 with an idle cycle between each grant.
- Pointer skip: ptr=5 with req=16'h8011. Winner is 15, then 0, then 4.
- Timeout with MAX_HOLD=8: req[2] held high, done=0. gnt=0004 for 8 cycles, timeout pulses once, gnt goes to 0. Requester 2 is re-granted after the idle cycle if still alone.
- Request drop and tie: owner 6 drops req[6] with req[9] asserted, so release is followed by a grant to 9. Separately, done and timeout in the same cycle gives release with timeout=0.
